// File: rtl/dp_ram_arbiter.sv
// dp_ram_arbiter: shares one dp_ram write port and one read port between two
// clients. Each port has an independent 1-bit round-robin arbiter with
// combinational grants; winning commands are registered onto the RAM pins and
// read data is routed back to its owner with a per-client valid strobe.
// Optional build macro: DPRA_RAW_STALL_EN (holds off a read whose address
// matches the same-cycle write winner, so the read returns the new data).
module dp_ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          c_wr_req,
  input  logic [2*ADDR_W-1:0] c_wr_addr,
  input  logic [2*DATA_W-1:0] c_wr_data,
  output logic [1:0]          c_wr_gnt,
  input  logic [1:0]          c_rd_req,
  input  logic [2*ADDR_W-1:0] c_rd_addr,
  output logic [1:0]          c_rd_gnt,
  output logic [1:0]          c_rd_valid,
  output logic [DATA_W-1:0]   c_rd_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   w_dataa,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   r_data
);

  // round-robin pointers: client that won the last transfer on each port
  logic wr_last_q, rd_last_q;
  // owner of the read currently on the RAM pins, then its trip to the tail
  logic              rd_own_q;
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [RD_LAT-1:0] own_pipe_q;

  logic              wr_win, rd_win, wr_fire, rd_fire, rd_block;
  logic [ADDR_W-1:0] wr_win_addr, rd_win_addr;
  logic [DATA_W-1:0] wr_win_data;

  // winner selection: on a tie the client other than `last` wins
  assign wr_win      = (&c_wr_req) ? ~wr_last_q : c_wr_req[1];
  assign rd_win      = (&c_rd_req) ? ~rd_last_q : c_rd_req[1];
  assign wr_win_addr = wr_win ? c_wr_addr[2*ADDR_W-1:ADDR_W] : c_wr_addr[ADDR_W-1:0];
  assign wr_win_data = wr_win ? c_wr_data[2*DATA_W-1:DATA_W] : c_wr_data[DATA_W-1:0];
  assign rd_win_addr = rd_win ? c_rd_addr[2*ADDR_W-1:ADDR_W] : c_rd_addr[ADDR_W-1:0];

`ifdef DPRA_RAW_STALL_EN
  // same-cycle read of the address being written waits one cycle
  assign rd_block = (|c_wr_req) & (|c_rd_req) & (rd_win_addr == wr_win_addr);
`else
  assign rd_block = 1'b0;
`endif

  // grants are suppressed while reset is asserted
  assign wr_fire  = (|c_wr_req) & rst;
  assign rd_fire  = (|c_rd_req) & ~rd_block & rst;
  assign c_wr_gnt = {wr_fire & wr_win, wr_fire & ~wr_win};
  assign c_rd_gnt = {rd_fire & rd_win, rd_fire & ~rd_win};

  // write port: register the winning command onto the RAM write pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      w_dataa   <= '0;
      wr_last_q <= 1'b1;
    end else begin
      wr_en <= wr_fire;
      if (wr_fire) begin
        wr_addr   <= wr_win_addr;
        w_dataa   <= wr_win_data;
        wr_last_q <= wr_win;
      end
    end
  end

  // read port: register the winning address and remember who asked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_own_q  <= 1'b0;
      rd_last_q <= 1'b1;
    end else begin
      rd_en <= rd_fire;
      if (rd_fire) begin
        rd_addr   <= rd_win_addr;
        rd_own_q  <= rd_win;
        rd_last_q <= rd_win;
      end
    end
  end

  // owner pipeline: starts when the RAM samples rd_en, so the tail lines up
  // with r_data RD_LAT cycles later; reset drops every in-flight read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      own_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= rd_en;
      own_pipe_q[0] <= rd_own_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        own_pipe_q[i] <= own_pipe_q[i-1];
      end
    end
  end

  // return path: capture RAM data and strobe the owning client
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rd_valid <= 2'b00;
      c_rd_data  <= '0;
    end else if (vld_pipe_q[RD_LAT-1]) begin
      c_rd_data  <= r_data;
      c_rd_valid <= own_pipe_q[RD_LAT-1] ? 2'b10 : 2'b01;
    end else begin
      c_rd_valid <= 2'b00;
    end
  end

endmodule
